// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, B-operand source codes, jump modes.
// Used by the decoder (cpu_id) and the execution unit (cpu_exu, cpu_alu).
package cpu_pkg;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_LD  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_NOT = 4'd7;
  localparam logic [3:0] ALU_SHL = 4'd8;
  localparam logic [3:0] ALU_SHR = 4'd9;
  localparam logic [3:0] ALU_ROL = 4'd10;
  localparam logic [3:0] ALU_ROR = 4'd11;
  localparam logic [3:0] ALU_ADC = 4'd12;
  localparam logic [3:0] ALU_SBB = 4'd13;
  localparam logic [3:0] ALU_CMP = 4'd14;
  localparam logic [3:0] ALU_INC = 4'd15;

  localparam logic [1:0] B_IMM = 2'd0;
  localparam logic [1:0] B_REG = 2'd1;
  localparam logic [1:0] B_MEM = 2'd2;
  localparam logic [1:0] B_ACC = 2'd3;

  localparam logic JMP_ALWAYS = 1'b0;
  localparam logic JMP_ZERO   = 1'b1;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A op B with carry in; R, C_OUT, Z_OUT and write strobes.
// Ports: A, B, C_IN, OP in; R, C_OUT, Z_OUT, WR_ACC, WR_FLAGS out.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int OPWIDTH = 4
) (
  input  logic [DWIDTH-1:0]  A,
  input  logic [DWIDTH-1:0]  B,
  input  logic               C_IN,
  input  logic [OPWIDTH-1:0] OP,
  output logic [DWIDTH-1:0]  R,
  output logic               C_OUT,
  output logic               Z_OUT,
  output logic               WR_ACC,
  output logic               WR_FLAGS
);

  logic [DWIDTH:0] a_x;
  logic [DWIDTH:0] b_x;
  logic [DWIDTH:0] c_x;
  logic [DWIDTH:0] one_x;
  logic [DWIDTH:0] wide;

  assign a_x   = {1'b0, A};
  assign b_x   = {1'b0, B};
  assign c_x   = {{DWIDTH{1'b0}}, C_IN};
  assign one_x = {{DWIDTH{1'b0}}, 1'b1};

  // Subtractions use the bit above the MSB as the borrow.
  always_comb begin
    R        = A;
    C_OUT    = C_IN;
    WR_ACC   = 1'b1;
    WR_FLAGS = 1'b1;
    wide     = '0;
    unique case (OP)
      ALU_NOP: begin
        WR_ACC   = 1'b0;
        WR_FLAGS = 1'b0;
      end
      ALU_LD:  R = B;
      ALU_ADD: begin
        wide  = a_x + b_x;
        R     = wide[DWIDTH-1:0];
        C_OUT = wide[DWIDTH];
      end
      ALU_SUB, ALU_CMP: begin
        wide   = a_x - b_x;
        R      = wide[DWIDTH-1:0];
        C_OUT  = wide[DWIDTH];
        WR_ACC = (OP != ALU_CMP);
      end
      ALU_AND: begin R = A & B; C_OUT = 1'b0; end
      ALU_OR:  begin R = A | B; C_OUT = 1'b0; end
      ALU_XOR: begin R = A ^ B; C_OUT = 1'b0; end
      ALU_NOT: begin R = ~A;    C_OUT = 1'b0; end
      ALU_SHL: begin
        R     = {A[DWIDTH-2:0], 1'b0};
        C_OUT = A[DWIDTH-1];
      end
      ALU_SHR: begin
        R     = {1'b0, A[DWIDTH-1:1]};
        C_OUT = A[0];
      end
      ALU_ROL: begin
        R     = {A[DWIDTH-2:0], C_IN};
        C_OUT = A[DWIDTH-1];
      end
      ALU_ROR: begin
        R     = {C_IN, A[DWIDTH-1:1]};
        C_OUT = A[0];
      end
      ALU_ADC: begin
        wide  = a_x + b_x + c_x;
        R     = wide[DWIDTH-1:0];
        C_OUT = wide[DWIDTH];
      end
      ALU_SBB: begin
        wide  = a_x - b_x - c_x;
        R     = wide[DWIDTH-1:0];
        C_OUT = wide[DWIDTH];
      end
      ALU_INC: begin
        wide  = a_x + one_x;
        R     = wide[DWIDTH-1:0];
        C_OUT = wide[DWIDTH];
      end
      default: begin
        WR_ACC   = 1'b0;
        WR_FLAGS = 1'b0;
      end
    endcase
  end

  assign Z_OUT = (R == '0);

endmodule

// File: rtl/cpu_exu.sv
// Execution unit: accumulator, 16-entry register file, C/Z flags, B mux, COND_OK.
// Ports: CLK, RST(async low), decoder controls in; ACC_OUT, REG_OUT, flags, COND_OK out.
module cpu_exu
  import cpu_pkg::*;
#(
  parameter int DWIDTH         = 8,
  parameter int OPWIDTH        = 4,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [OPWIDTH-1:0]        ALU_OP,
  input  logic [DWIDTH-1:0]         IMM,
  input  logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL,
  input  logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
  input  logic                      EN_REG_F,
  input  logic                      EN_ACC,
  input  logic [DWIDTH-1:0]         D_MEM_DATA,
  input  logic                      JMP_MODE,
  output logic [DWIDTH-1:0]         ACC_OUT,
  output logic [DWIDTH-1:0]         REG_OUT,
  output logic                      FLAG_C,
  output logic                      FLAG_Z,
  output logic                      COND_OK
);

  localparam int NREG = 2 ** REG_F_SEL_SIZE;

  logic [DWIDTH-1:0] acc_q, acc_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;
  logic [DWIDTH-1:0] reg_f_q [NREG];
  logic [DWIDTH-1:0] reg_f_d [NREG];

  logic [DWIDTH-1:0] b_op;
  logic [DWIDTH-1:0] alu_r;
  logic              alu_c;
  logic              alu_z;
  logic              alu_wr_acc;
  logic              alu_wr_flags;

  assign REG_OUT = reg_f_q[REG_F_SEL];

  // B_ACC deliberately reads the pre-edge accumulator.
  always_comb begin
    b_op = IMM;
    unique case (IN_B_SEL)
      B_IMM:   b_op = IMM;
      B_REG:   b_op = REG_OUT;
      B_MEM:   b_op = D_MEM_DATA;
      B_ACC:   b_op = acc_q;
      default: b_op = IMM;
    endcase
  end

  cpu_alu #(
    .DWIDTH  (DWIDTH),
    .OPWIDTH (OPWIDTH)
  ) u_alu (
    .A        (acc_q),
    .B        (b_op),
    .C_IN     (flag_c_q),
    .OP       (ALU_OP),
    .R        (alu_r),
    .C_OUT    (alu_c),
    .Z_OUT    (alu_z),
    .WR_ACC   (alu_wr_acc),
    .WR_FLAGS (alu_wr_flags)
  );

  always_comb begin
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (EN_ACC && alu_wr_acc) acc_d = alu_r;
    if (EN_ACC && alu_wr_flags) begin
      flag_c_d = alu_c;
      flag_z_d = alu_z;
    end
  end

  // Register write takes the old ACC, so LD from the same register swaps.
  always_comb begin
    reg_f_d = reg_f_q;
    if (EN_REG_F) reg_f_d[REG_F_SEL] = acc_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q    <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      for (int i = 0; i < NREG; i++) reg_f_q[i] <= '0;
    end else begin
      acc_q    <= acc_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      reg_f_q  <= reg_f_d;
    end
  end

  assign ACC_OUT = acc_q;
  assign FLAG_C  = flag_c_q;
  assign FLAG_Z  = flag_z_q;
  assign COND_OK = (JMP_MODE == JMP_ZERO) ? flag_z_q : 1'b1;

endmodule

// File: tb/tb_cpu_exu.sv
// Directed bench for cpu_exu: reset, arithmetic, swap, shifts, branch cond.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cpu_exu;
  import cpu_pkg::*;

  logic       CLK;
  logic       RST;
  logic [3:0] ALU_OP;
  logic [7:0] IMM;
  logic [1:0] IN_B_SEL;
  logic [3:0] REG_F_SEL;
  logic       EN_REG_F;
  logic       EN_ACC;
  logic [7:0] D_MEM_DATA;
  logic       JMP_MODE;
  logic [7:0] ACC_OUT;
  logic [7:0] REG_OUT;
  logic       FLAG_C;
  logic       FLAG_Z;
  logic       COND_OK;

  int n_chk  = 0;
  int n_pass = 0;

  cpu_exu dut (
    .CLK        (CLK),
    .RST        (RST),
    .ALU_OP     (ALU_OP),
    .IMM        (IMM),
    .IN_B_SEL   (IN_B_SEL),
    .REG_F_SEL  (REG_F_SEL),
    .EN_REG_F   (EN_REG_F),
    .EN_ACC     (EN_ACC),
    .D_MEM_DATA (D_MEM_DATA),
    .JMP_MODE   (JMP_MODE),
    .ACC_OUT    (ACC_OUT),
    .REG_OUT    (REG_OUT),
    .FLAG_C     (FLAG_C),
    .FLAG_Z     (FLAG_Z),
    .COND_OK    (COND_OK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Apply one operation for one clock; returns at the next falling edge.
  task automatic step(input logic [3:0] op, input logic [1:0] bsel,
                      input logic [7:0] imm, input logic en_a,
                      input logic en_r, input logic [3:0] sel);
    ALU_OP    = op;
    IN_B_SEL  = bsel;
    IMM       = imm;
    EN_ACC    = en_a;
    EN_REG_F  = en_r;
    REG_F_SEL = sel;
    @(posedge CLK);
    @(negedge CLK);
    EN_ACC   = 1'b0;
    EN_REG_F = 1'b0;
  endtask

  task automatic ld(input logic [7:0] v);
    step(ALU_LD, B_IMM, v, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic flags(input string tag, input logic c, input logic z);
    chk({tag, "_c"}, {7'd0, FLAG_C}, {7'd0, c});
    chk({tag, "_z"}, {7'd0, FLAG_Z}, {7'd0, z});
  endtask

  initial begin
    RST        = 1'b1;
    ALU_OP     = ALU_NOP;
    IMM        = 8'h00;
    IN_B_SEL   = B_IMM;
    REG_F_SEL  = 4'd0;
    EN_REG_F   = 1'b0;
    EN_ACC     = 1'b0;
    D_MEM_DATA = 8'h00;
    JMP_MODE   = JMP_ALWAYS;
    #1 RST = 1'b0;

    // Enables toggle while reset is held.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      ALU_OP    = 4'($urandom_range(1, 15));
      IMM       = 8'($urandom);
      IN_B_SEL  = 2'($urandom);
      REG_F_SEL = 4'($urandom);
      EN_ACC    = 1'b1;
      EN_REG_F  = 1'b1;
    end
    @(negedge CLK);
    EN_ACC   = 1'b0;
    EN_REG_F = 1'b0;
    chk("rst_acc", ACC_OUT, 8'h00);
    flags("rst", 1'b0, 1'b0);
    for (int r = 0; r < 16; r++) begin
      REG_F_SEL = 4'(r);
      #1 chk($sformatf("rst_reg%0d", r), REG_OUT, 8'h00);
    end
    JMP_MODE = JMP_ALWAYS;
    #1 chk("rst_cond_always", {7'd0, COND_OK}, 8'h01);
    JMP_MODE = JMP_ZERO;
    #1 chk("rst_cond_zero", {7'd0, COND_OK}, 8'h00);
    JMP_MODE = JMP_ALWAYS;
    @(negedge CLK);
    RST = 1'b1;

    // Add with carry chain.
    ld(8'hF0);
    chk("ld_f0", ACC_OUT, 8'hF0);
    step(ALU_ADD, B_IMM, 8'h20, 1'b1, 1'b0, 4'd0);
    chk("add_acc", ACC_OUT, 8'h10);
    flags("add", 1'b1, 1'b0);
    step(ALU_ADC, B_IMM, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("adc_acc", ACC_OUT, 8'h11);
    flags("adc", 1'b0, 1'b0);

    // EN_ACC low: nothing changes.
    step(ALU_ADD, B_IMM, 8'h33, 1'b0, 1'b0, 4'd0);
    chk("noen_acc", ACC_OUT, 8'h11);

    // Subtract to zero and branch condition.
    ld(8'h05);
    step(ALU_SUB, B_IMM, 8'h05, 1'b1, 1'b0, 4'd0);
    chk("sub_acc", ACC_OUT, 8'h00);
    flags("sub", 1'b0, 1'b1);
    JMP_MODE = JMP_ZERO;
    #1 chk("cond_z1", {7'd0, COND_OK}, 8'h01);

    // Compare leaves ACC alone.
    ld(8'h03);
    #1 chk("cond_z0", {7'd0, COND_OK}, 8'h00);
    JMP_MODE = JMP_ALWAYS;
    #1 chk("cond_always", {7'd0, COND_OK}, 8'h01);
    step(ALU_CMP, B_IMM, 8'h04, 1'b1, 1'b0, 4'd0);
    chk("cmp_acc", ACC_OUT, 8'h03);
    flags("cmp", 1'b1, 1'b0);

    // Register file swap through REG_F[7].
    ld(8'hAA);
    step(ALU_NOP, B_IMM, 8'h00, 1'b0, 1'b1, 4'd7);
    REG_F_SEL = 4'd7;
    #1 chk("reg7_wr", REG_OUT, 8'hAA);
    ld(8'h55);
    step(ALU_LD, B_REG, 8'h00, 1'b1, 1'b1, 4'd7);
    chk("swap_acc", ACC_OUT, 8'hAA);
    REG_F_SEL = 4'd7;
    #1 chk("swap_reg7", REG_OUT, 8'h55);
    REG_F_SEL = 4'd6;
    #1 chk("reg6_clean", REG_OUT, 8'h00);

    // Shift and rotate.
    ld(8'h81);
    step(ALU_AND, B_IMM, 8'hFF, 1'b1, 1'b0, 4'd0);
    flags("and", 1'b0, 1'b0);
    step(ALU_ROL, B_IMM, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("rol_acc", ACC_OUT, 8'h02);
    flags("rol", 1'b1, 1'b0);
    step(ALU_ROR, B_IMM, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("ror_acc", ACC_OUT, 8'h81);
    flags("ror", 1'b0, 1'b0);
    ld(8'h01);
    step(ALU_SHR, B_IMM, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("shr_acc", ACC_OUT, 8'h00);
    flags("shr", 1'b1, 1'b1);

    // NOP with EN_ACC keeps ACC and flags.
    step(ALU_NOP, B_IMM, 8'h5A, 1'b1, 1'b0, 4'd0);
    chk("nop_acc", ACC_OUT, 8'h00);
    flags("nop", 1'b1, 1'b1);

    // Memory and ACC operands, INC wrap, SBB.
    D_MEM_DATA = 8'h3C;
    step(ALU_LD, B_MEM, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("ld_mem", ACC_OUT, 8'h3C);
    step(ALU_ADD, B_ACC, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("add_acc_self", ACC_OUT, 8'h78);
    flags("add_self", 1'b0, 1'b0);
    ld(8'hFF);
    step(ALU_INC, B_IMM, 8'h00, 1'b1, 1'b0, 4'd0);
    chk("inc_acc", ACC_OUT, 8'h00);
    flags("inc", 1'b1, 1'b1);
    ld(8'h10);
    step(ALU_SBB, B_IMM, 8'h0F, 1'b1, 1'b0, 4'd0);
    chk("sbb_acc", ACC_OUT, 8'h00);
    flags("sbb", 1'b0, 1'b1);

    // Asynchronous reset mid-cycle beats a pending load.
    ld(8'h77);
    ALU_OP   = ALU_LD;
    IMM      = 8'h99;
    EN_ACC   = 1'b1;
    EN_REG_F = 1'b1;
    #2 RST = 1'b0;
    #1 chk("async_rst_acc", ACC_OUT, 8'h00);
    @(posedge CLK);
    @(negedge CLK);
    chk("async_rst_hold", ACC_OUT, 8'h00);
    EN_ACC   = 1'b0;
    EN_REG_F = 1'b0;
    RST      = 1'b1;
    step(ALU_LD, B_IMM, 8'h42, 1'b1, 1'b0, 4'd0);
    chk("post_rst_ld", ACC_OUT, 8'h42);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
